param_port_arbiter: RTL and testbench
=====================================

# param_port_arbiter

Parametrised N-requester arbiter between layer-parameter clients (read/write controllers and others) and the single-ported parameter module. Address requests use valid/ready and are arbitrated by fixed priority or round-robin. Up to MAX_OUTSTANDING requests may be in flight. Each parameter data beat is routed back to the requester that issued the matching address, in issue order.

## Interface
- NUM_REQ, 2, number of requesters (≥2)
- ADDR_W, 5, parameter address width (= $clog2(MAX_NUM_LAYERS)+1)
- DATA_W, 32, parameter word width (PARAM_WIDTH)
- MAX_OUTSTANDING, 2, in-flight address→data transactions (≥1)
- ARB_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round-robin
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- req_addr  in  NUM_REQ*ADDR_W  requester addresses, slice i = requester i
- req_addr_valid  in  NUM_REQ  address valid per requester
- req_addr_ready  out  NUM_REQ  address accepted per requester
- rsp_data  out  DATA_W  returned parameter word, shared by all requesters
- rsp_valid  out  NUM_REQ  data valid, one-hot to the owning requester
- rsp_ready  in  NUM_REQ  requester data ready
- p_addr  out  ADDR_W  address to param module
- p_addr_valid  out  1  address valid to param module
- p_addr_ready  in  1  param module accepts address
- p_data  in  DATA_W  param module data
- p_data_valid  in  1  param module data valid
- p_data_ready  out  1  arbiter accepts data
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  transactions in flight

## Operation
- Address stage: one output register holds p_addr/p_addr_valid plus its owner ID.
- can_accept = (register empty OR p_addr_valid & p_addr_ready this cycle) AND (id FIFO not full OR FIFO pop this cycle).
- Arbitration each cycle among the requesters with valid high:
  - ARB_MODE 0: lowest index wins.
  - ARB_MODE 1: search starts at rr_ptr, wrapping modulo NUM_REQ.
- req_addr_ready[i] = can_accept & grant[i]. This is combinational from valids and p_addr_ready/pop. At most one bit is high.
- On accept: load req_addr slice into p_addr, set p_addr_valid, push the winner ID into the ID FIFO.
- In round-robin mode only, rr_ptr ← (winner+1) mod NUM_REQ. rr_ptr holds when nothing is accepted.
- p_addr_valid clears on p_addr handshake unless a new accept happens in the same cycle. It never drops without a handshake. p_addr is stable while valid.
- Data stage is combinational pass-through:
  - rsp_data = p_data.
  - rsp_valid[head] = p_data_valid & !fifo_empty; all other bits are 0.
  - p_data_ready = rsp_ready[head] & !fifo_empty.
- p_data handshake pops the FIFO head.
- When the FIFO is empty, p_data_ready=0 and rsp_valid=0. Unsolicited data stalls and is never dropped.
- outstanding = FIFO count: +1 on push, −1 on pop, unchanged on simultaneous push and pop.
- A requester must hold valid and address until ready. Dropping valid early is a protocol violation and is not checked.

## Timing
- Reset values: p_addr_valid=0, p_addr=0, rsp_valid=0, req_addr_ready=0, p_data_ready=0, outstanding=0, rr_ptr=0, FIFO empty.
- Address latency: accepted at cycle N → p_addr_valid at N+1. Back-to-back accepts sustain 1 address/cycle while p_addr_ready=1 and the FIFO has room.
- Data latency: 0 cycles from p_data_valid to rsp_valid.
- Full FIFO with a pop in the same cycle: accept is allowed, and the count is unchanged.
- Full FIFO with no pop: all req_addr_ready=0.
- Reset mid-operation clears the FIFO and address register. Data returned after reset stalls (p_data_ready=0). The param module must be reset together with the arbiter.

## Structure
- Shared package param_pkg: PARAM_WIDTH, MAX_NUM_LAYERS, arb_mode_e {ARB_FIXED, ARB_RR}.
- Sub-module param_id_fifo: synchronous FIFO of $clog2(NUM_REQ)-bit IDs, depth MAX_OUTSTANDING, with push, pop, full, empty and count.
  - Pointers wrap modulo depth.
  - Depth need not be a power of two.
- Arbiter logic and the address register live in the top level.

## Test plan
- Reset: hold rst_n=0 3 cycles with all valids high → all outputs 0; first accept occurs in the cycle after rst_n rises, p_addr_valid visible one cycle later.
- Fixed priority, NUM_REQ=2: both valid continuously (addr 3 and 7), p_addr_ready=1, data returned 2 cycles later → requester 0 always granted, requester 1 starved; every rsp_valid is on bit 0.
- Round-robin, NUM_REQ=3: all valid continuously → grant order 0,1,2,0,1,2; each response goes to the issuing requester in order.
- Outstanding limit, MAX_OUTSTANDING=2, data withheld: two accepts, then req_addr_ready=0 and outstanding=2. A p_data beat with rsp_ready=1 in the same cycle as a pending request → accept proceeds that cycle, outstanding stays 2.
- Backpressure: p_addr_ready=0 for 4 cycles → p_addr stable and valid. Then rsp_ready[head]=0 while p_data_valid=1 → p_data_ready=0, no pop, and rsp_data is delivered once rsp_ready rises.
- Unsolicited data: p_data_valid=1 with empty FIFO → p_data_ready=0, all rsp_valid=0, no state change.

Source files
------------

// File: rtl/param_pkg.sv
// Shared constants and types for the layer-parameter subsystem.
package param_pkg;

  localparam int PARAM_WIDTH    = 32;
  localparam int MAX_NUM_LAYERS = 16;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

endpackage

// File: rtl/param_id_fifo.sv
// Small synchronous FIFO of requester IDs, one entry per address in flight.
// Depth may be any value; pointers wrap explicitly rather than by overflow.
module param_id_fifo
  import param_pkg::*;
#(
  parameter int ID_W  = 1,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [ID_W-1:0]  din,
  input  logic             pop,
  output logic [ID_W-1:0]  dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/param_port_arbiter.sv
// Arbitrates N parameter clients onto the single-ported parameter module and
// steers each returning data beat to the client that issued its address.
module param_port_arbiter
  import param_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_W          = $clog2(MAX_NUM_LAYERS) + 1,
  parameter int DATA_W          = PARAM_WIDTH,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ARB_MODE        = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0]            req_addr,
  input  logic [NUM_REQ-1:0]                   req_addr_valid,
  output logic [NUM_REQ-1:0]                   req_addr_ready,
  output logic [DATA_W-1:0]                    rsp_data,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  input  logic [NUM_REQ-1:0]                   rsp_ready,
  output logic [ADDR_W-1:0]                    p_addr,
  output logic                                 p_addr_valid,
  input  logic                                 p_addr_ready,
  input  logic [DATA_W-1:0]                    p_data,
  input  logic                                 p_data_valid,
  output logic                                 p_data_ready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam bit RR_MODE = (ARB_MODE == int'(ARB_RR));

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    head_id;
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0]  win_addr;
  logic               any_valid;
  logic               can_accept;
  logic               accept;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;

  // Fixed priority scans from index 0; round-robin scans from rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    winner    = '0;
    win_addr  = '0;
    any_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = RR_MODE ? (int'(rr_ptr) + k) % NUM_REQ : k;
      if (!any_valid && req_addr_valid[idx]) begin
        any_valid  = 1'b1;
        winner     = ID_W'(idx);
        grant[idx] = 1'b1;
        win_addr   = req_addr[idx*ADDR_W +: ADDR_W];
      end
    end
  end

  // A full ID FIFO still accepts when a data beat frees its head this cycle.
  assign can_accept     = rst_n && (!p_addr_valid || p_addr_ready) && (!fifo_full || fifo_pop);
  assign accept         = can_accept && any_valid;
  assign req_addr_ready = can_accept ? grant : '0;

  always_comb begin
    rsp_data     = p_data;
    rsp_valid    = '0;
    p_data_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (head_id == ID_W'(i)) begin
        rsp_valid[i] = p_data_valid && !fifo_empty && rst_n;
        p_data_ready = rsp_ready[i] && !fifo_empty && rst_n;
      end
    end
  end

  assign fifo_pop = p_data_valid && p_data_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_addr       <= '0;
      p_addr_valid <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      if (accept) begin
        p_addr       <= win_addr;
        p_addr_valid <= 1'b1;
        if (RR_MODE) rr_ptr <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
      end else if (p_addr_ready) begin
        p_addr_valid <= 1'b0;
      end
    end
  end

  param_id_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W ($clog2(MAX_OUTSTANDING + 1))
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (winner),
    .pop   (fifo_pop),
    .dout  (head_id),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

endmodule

// File: tb/tb_param_port_arbiter.sv
// Scoreboard bench: one fixed-priority and one round-robin arbiter, each
// driven against a small behavioural model of the parameter module.
module tb_param_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] req_addr       [2];
  logic [2:0]  req_addr_valid [2];
  logic [2:0]  req_addr_ready [2];
  logic [31:0] rsp_data       [2];
  logic [2:0]  rsp_valid      [2];
  logic [2:0]  rsp_ready      [2];
  logic [4:0]  p_addr         [2];
  logic        p_addr_valid   [2];
  logic        p_addr_ready   [2];
  logic [31:0] p_data         [2];
  logic        p_data_valid   [2];
  logic        p_data_ready   [2];
  logic [1:0]  outstanding    [2];

  always #5 clk = ~clk;

  param_port_arbiter #(
    .NUM_REQ(3), .ADDR_W(5), .DATA_W(32), .MAX_OUTSTANDING(2), .ARB_MODE(0)
  ) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr[0]), .req_addr_valid(req_addr_valid[0]), .req_addr_ready(req_addr_ready[0]),
    .rsp_data(rsp_data[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .p_addr(p_addr[0]), .p_addr_valid(p_addr_valid[0]), .p_addr_ready(p_addr_ready[0]),
    .p_data(p_data[0]), .p_data_valid(p_data_valid[0]), .p_data_ready(p_data_ready[0]),
    .outstanding(outstanding[0])
  );

  param_port_arbiter #(
    .NUM_REQ(3), .ADDR_W(5), .DATA_W(32), .MAX_OUTSTANDING(2), .ARB_MODE(1)
  ) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req_addr(req_addr[1]), .req_addr_valid(req_addr_valid[1]), .req_addr_ready(req_addr_ready[1]),
    .rsp_data(rsp_data[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .p_addr(p_addr[1]), .p_addr_valid(p_addr_valid[1]), .p_addr_ready(p_addr_ready[1]),
    .p_data(p_data[1]), .p_data_valid(p_data_valid[1]), .p_data_ready(p_data_ready[1]),
    .outstanding(outstanding[1])
  );

  typedef struct { int r; logic [4:0] a; } exp_t;
  typedef struct { int t; logic [4:0] a; } pm_t;

  exp_t       exp_q [$];
  pm_t        pm_q  [$];
  int         glog  [$];
  int         errors;
  int         checks;
  int         cyc;
  logic       rst_set;
  logic       pready_set;
  logic       mem_en;
  logic       unsol;
  int         mem_lat;
  logic [2:0] val_set;
  logic [2:0] rsp_ready_set;
  logic [4:0] addr_tab [3];

  function automatic logic [31:0] dataOf(input logic [4:0] a);
    return {3'b101, a, 8'hC3, 11'h2A5, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock: drive inputs just after the edge, sample near the next one.
  task automatic applyStimulus(input int d);
    exp_t e;
    pm_t  p;
    @(posedge clk);
    #1;
    rst_n             = rst_set;
    req_addr[d]       = {addr_tab[2], addr_tab[1], addr_tab[0]};
    req_addr_valid[d] = val_set;
    rsp_ready[d]      = rsp_ready_set;
    p_addr_ready[d]   = pready_set;
    p_data_valid[d]   = 1'b0;
    p_data[d]         = '0;
    if (unsol) begin
      p_data_valid[d] = 1'b1;
      p_data[d]       = 32'hDEAD_BEEF;
    end else if (mem_en && pm_q.size() > 0 && (cyc - pm_q[0].t) >= mem_lat) begin
      p_data_valid[d] = 1'b1;
      p_data[d]       = dataOf(pm_q[0].a);
    end
    #4;
    if (p_data_valid[d] && p_data_ready[d]) begin
      if (!unsol && pm_q.size() > 0) void'(pm_q.pop_front());
      if (exp_q.size() == 0) checkOutput("spurious_rsp", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        checkOutput("rsp_valid", 32'(rsp_valid[d]), 32'd1 << e.r);
        checkOutput("rsp_data", rsp_data[d], dataOf(e.a));
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (req_addr_valid[d][i] && req_addr_ready[d][i]) begin
        e.r = i;
        e.a = addr_tab[i];
        exp_q.push_back(e);
        glog.push_back(i);
      end
    end
    if (p_addr_valid[d] && p_addr_ready[d]) begin
      p.t = cyc;
      p.a = p_addr[d];
      pm_q.push_back(p);
    end
    if (!rst_set) begin
      exp_q.delete();
      pm_q.delete();
    end
    cyc++;
  endtask

  task automatic doReset(input int d);
    rst_set = 1'b0; val_set = '0; mem_en = 1'b0; unsol = 1'b0;
    pready_set = 1'b1; rsp_ready_set = 3'b111; mem_lat = 1;
    repeat (2) applyStimulus(d);
    rst_set = 1'b1;
    glog.delete();
  endtask

  task automatic drainAll(input int d);
    val_set = '0;
    for (int k = 0; k < 60 && exp_q.size() > 0; k++) applyStimulus(d);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    applyStimulus(d);
    checkOutput("drain_outstanding", 32'(outstanding[d]), 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    addr_tab[0] = 5'd3; addr_tab[1] = 5'd7; addr_tab[2] = 5'd11;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_addr_valid[d] = '0; rsp_ready[d] = '0;
      p_addr_ready[d] = 1'b0; p_data[d] = '0; p_data_valid[d] = 1'b0;
    end
    rst_set = 1'b0; pready_set = 1'b1; rsp_ready_set = 3'b111;
    mem_en = 1'b0; mem_lat = 1; unsol = 1'b0;

    // Reset held with every requester asserting valid.
    val_set = 3'b111;
    repeat (3) applyStimulus(1);
    checkOutput("rst_req_ready", 32'(req_addr_ready[1]), 32'd0);
    checkOutput("rst_p_addr_valid", 32'(p_addr_valid[1]), 32'd0);
    checkOutput("rst_p_addr", 32'(p_addr[1]), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    checkOutput("rst_p_data_ready", 32'(p_data_ready[1]), 32'd0);
    checkOutput("rst_outstanding", 32'(outstanding[1]), 32'd0);

    // Round-robin continues straight out of reset.
    glog.delete();
    mem_en = 1'b1; mem_lat = 1; rst_set = 1'b1;
    applyStimulus(1);
    checkOutput("first_accept", 32'(req_addr_ready[1]), 32'b001);
    checkOutput("first_p_addr_valid", 32'(p_addr_valid[1]), 32'd0);
    applyStimulus(1);
    checkOutput("second_p_addr_valid", 32'(p_addr_valid[1]), 32'd1);
    checkOutput("second_p_addr", 32'(p_addr[1]), 32'd3);
    repeat (12) applyStimulus(1);
    drainAll(1);
    checkOutput("rr_rate", 32'(glog.size() >= 12), 32'd1);
    for (int k = 0; k < glog.size(); k++) checkOutput("rr_order", glog[k], k % 3);

    // Fixed priority: requester 1 must starve behind requester 0.
    doReset(0);
    val_set = 3'b011; mem_en = 1'b1; mem_lat = 2;
    repeat (16) applyStimulus(0);
    drainAll(0);
    checkOutput("fixed_count", 32'(glog.size() >= 4), 32'd1);
    for (int k = 0; k < glog.size(); k++) checkOutput("fixed_grant", glog[k], 32'd0);

    // Outstanding limit, then accept through a full FIFO with a pop.
    doReset(1);
    val_set = 3'b001;
    applyStimulus(1);
    checkOutput("out_accept0", 32'(req_addr_ready[1]), 32'b001);
    applyStimulus(1);
    checkOutput("out_accept1", 32'(req_addr_ready[1]), 32'b001);
    checkOutput("out_count1", 32'(outstanding[1]), 32'd1);
    applyStimulus(1);
    checkOutput("out_full_ready", 32'(req_addr_ready[1]), 32'd0);
    checkOutput("out_full_count", 32'(outstanding[1]), 32'd2);
    applyStimulus(1);
    checkOutput("out_full_hold", 32'(req_addr_ready[1]), 32'd0);
    mem_en = 1'b1;
    applyStimulus(1);
    checkOutput("full_pop_accept", 32'(req_addr_ready[1]), 32'b001);
    checkOutput("full_pop_dready", 32'(p_data_ready[1]), 32'd1);
    checkOutput("full_pop_count", 32'(outstanding[1]), 32'd2);
    applyStimulus(1);
    checkOutput("full_pop_count_after", 32'(outstanding[1]), 32'd2);

    // Reset mid-flight, then data arriving with nothing outstanding.
    rst_set = 1'b0;
    applyStimulus(1);
    rst_set = 1'b1; val_set = '0; mem_en = 1'b0; unsol = 1'b1;
    applyStimulus(1);
    checkOutput("unsol_dready", 32'(p_data_ready[1]), 32'd0);
    checkOutput("unsol_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    checkOutput("unsol_outstanding", 32'(outstanding[1]), 32'd0);
    checkOutput("unsol_p_addr_valid", 32'(p_addr_valid[1]), 32'd0);
    applyStimulus(1);
    checkOutput("unsol_dready_hold", 32'(p_data_ready[1]), 32'd0);
    checkOutput("unsol_outstanding_hold", 32'(outstanding[1]), 32'd0);
    unsol = 1'b0;

    // Address backpressure, then response backpressure.
    doReset(1);
    pready_set = 1'b0; val_set = 3'b010; mem_en = 1'b1; mem_lat = 1;
    applyStimulus(1);
    checkOutput("bp_accept", 32'(req_addr_ready[1]), 32'b010);
    val_set = '0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1);
      checkOutput("bp_p_addr_valid", 32'(p_addr_valid[1]), 32'd1);
      checkOutput("bp_p_addr", 32'(p_addr[1]), 32'd7);
    end
    pready_set = 1'b1;
    applyStimulus(1);
    rsp_ready_set = 3'b101;
    applyStimulus(1);
    checkOutput("bp_dready_low", 32'(p_data_ready[1]), 32'd0);
    checkOutput("bp_rsp_valid", 32'(rsp_valid[1]), 32'b010);
    checkOutput("bp_rsp_data", rsp_data[1], dataOf(5'd7));
    checkOutput("bp_outstanding", 32'(outstanding[1]), 32'd1);
    applyStimulus(1);
    checkOutput("bp_dready_hold", 32'(p_data_ready[1]), 32'd0);
    checkOutput("bp_outstanding_hold", 32'(outstanding[1]), 32'd1);
    rsp_ready_set = 3'b111;
    applyStimulus(1);
    checkOutput("bp_dready_high", 32'(p_data_ready[1]), 32'd1);
    applyStimulus(1);
    checkOutput("bp_outstanding_done", 32'(outstanding[1]), 32'd0);
    checkOutput("bp_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
